keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces the presses, encodes each key into the calculator's 4-bit key code and emits a `kbEN` strobe. It is the transmitting end of the key interface consumed by the calculator control FSM. That FSM captures `pressedkey` on the falling edge of `kbEN`, so this block guarantees `pressedkey` is stable for the whole strobe and afterwards.

## Interface
- `SCAN_DIV`, 50000: clk cycles each row is driven before its columns are sampled (the dwell). Must be at least 4.
- `DEBOUNCE_SCANS`, 10: consecutive identical samples required to accept a press or a release. Must be at least 1.
- `KBEN_CYCLES`, 4: number of clk cycles `kbEN` is held high per key event. Must be at least 1.
- `REPEAT_SAMPLES`, 500: held samples before an auto-repeat fires. Used only with `KEYPAD_AUTOREPEAT_EN`.

Ports:
- `clk` input 1: single system clock.
- `rst` input 1: asynchronous, active-high reset.
- `cols` input 4: keypad columns, active-low with external pull-ups, asynchronous to `clk`.
- `rows` output 4: row drive, active-low, exactly one row low at any time.
- `pressedkey` output 4: key code of the last accepted key.
- `kbEN` output 1: key strobe; its falling edge marks a valid `pressedkey`.

## Operation
- Key map, written as row r / col c -> code:
  - Row 0: 1, 2, 3, 4'hC (plus).
  - Row 1: 4, 5, 6, 4'hD (minus).
  - Row 2: 7, 8, 9, 4'hE (mult).
  - Row 3: 4'hB (AC), 0, 4'hA (equal), 4'hF (div).
- `cols` passes through a 2-flop synchronizer before any use.
- A dwell counter runs 0..SCAN_DIV-1. A "sample" is taken of synchronized `cols` when the counter reaches SCAN_DIV-1.
- SCAN:
  - Drive `rows` = ~(1<<r).
  - At each sample, if all columns are high, advance r (3 wraps to 0).
  - Otherwise record the pattern and the lowest-index low column, then go to DEBOUNCE. r is held.
- DEBOUNCE:
  - The same row stays driven.
  - Each later sample equal to the recorded pattern increments the match count. The first detection counts as 1.
  - Any differing sample returns to SCAN and advances r.
  - When the count reaches DEBOUNCE_SCANS, load `pressedkey` and go to STROBE.
- STROBE: `kbEN` is held 1 for KBEN_CYCLES cycles, then driven 0. Go to WAIT_RELEASE.
- WAIT_RELEASE:
  - The same row stays driven.
  - DEBOUNCE_SCANS consecutive all-high samples return to SCAN and advance r.
  - A non-all-high sample resets the release count.
- Multiple keys:
  - On the same row, the lowest column index wins.
  - On different rows, the first row scanned wins.
  - Keys on other rows are ignored until release.
- `pressedkey` holds its value until the next accepted key. It never changes while `kbEN` = 1 or on the cycle `kbEN` falls.

## Timing
- Reset values: `rows` = 4'b1110, `pressedkey` = 4'h0, `kbEN` = 0, state SCAN, r = 0, counters 0.
- Reset asserted mid-operation (including mid-strobe) forces the reset values immediately. No further strobe is emitted for a key held across reset until it has been released and pressed again.
- `pressedkey` and the rising edge of `kbEN` update on the same clk edge, in the cycle after the accepting sample.
- Press latency, from `cols` stable-low on the active row to `kbEN` rising: at most (DEBOUNCE_SCANS)*SCAN_DIV + 3 cycles.
- `kbEN` is high for exactly KBEN_CYCLES cycles. Consecutive strobes are separated by at least DEBOUNCE_SCANS*SCAN_DIV cycles.
- A row change takes effect at the cycle after a sample, which gives a full dwell of settling before the next sample.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In WAIT_RELEASE, REPEAT_SAMPLES consecutive samples equal to the accepted pattern re-enter STROBE with the same `pressedkey`.
  - The count restarts after each repeat.
  - A release still returns to SCAN as described in Operation.
- Not defined: one strobe per press, REPEAT_SAMPLES is ignored, and no repeat logic is synthesized.

## Test plan
Bench settings: SCAN_DIV=4, DEBOUNCE_SCANS=3, KBEN_CYCLES=2, REPEAT_SAMPLES=5.
- Reset then idle: `rows` cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, changing every 4 cycles; `kbEN` stays 0.
- Hold the row-1/col-2 key (code 6): exactly one strobe, `kbEN` high for 2 cycles, `pressedkey` = 4'h6 before the rise and after the fall. Latency is at most 15 cycles from the active-row sample.
- Bounce: col 3 on row 3 toggles every 3 cycles for 40 cycles, then stays low: no strobe during the bounce, then one strobe with `pressedkey` = 4'hF.
- Simultaneous row 0, col 1 and col 3 low: one strobe with 4'h2. Pressing row 2 while row 0 is still held gives no strobe. After full release and a press on row 2, col 0: strobe with 4'h7.
- Assert `rst` during the first `kbEN` cycle: `kbEN` drops immediately, `pressedkey` = 0, `rows` = 1110. While the key remains held after reset, no strobe occurs.
- Hold the row-3/col-2 key (equal) for 200 cycles:
  - With `KEYPAD_AUTOREPEAT_EN`: an initial strobe, then a repeat strobe of 4'hA every 22 cycles (5 samples × 4 cycles + 2).
  - Without the macro: exactly one strobe.

Source files
------------

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 active-low matrix keypad scanner. Drives one row low at
//                a time, samples the synchronized columns once per dwell,
//                debounces presses and releases, encodes the key into the
//                calculator's 4-bit code and emits a kbEN strobe.
//                Optional macro KEYPAD_AUTOREPEAT_EN adds auto-repeat of a
//                held key.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 10,
    parameter int KBEN_CYCLES    = 4,
    parameter int REPEAT_SAMPLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] pressedkey,
    output logic       kbEN
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int STB_W = $clog2(KBEN_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(KBEN_CYCLES - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SAMPLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SAMPLES - 1);
`endif

    localparam logic [1:0] ST_SCAN         = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
    localparam logic [1:0] ST_STROBE       = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    // Elaboration-time parameter sanity checks
    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce_scans
        $error("keypad_scanner: DEBOUNCE_SCANS must be at least 1");
    end
    if (KBEN_CYCLES < 1) begin : g_bad_kben_cycles
        $error("keypad_scanner: KBEN_CYCLES must be at least 1");
    end
    if (REPEAT_SAMPLES < 1) begin : g_bad_repeat_samples
        $error("keypad_scanner: REPEAT_SAMPLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]       cols_meta_q;
    logic [3:0]       cols_sync_q;
    logic [1:0]       state_q,   state_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [1:0]       row_q,     row_d;
    logic [3:0]       pattern_q, pattern_d;
    logic [1:0]       col_q,     col_d;
    logic [DEB_W-1:0] match_q,   match_d;
    logic [DEB_W-1:0] rel_q,     rel_d;
    logic [STB_W-1:0] stb_q,     stb_d;
    logic [3:0]       key_q,     key_d;
    // lock_q suppresses strobes for a key that may have been held through
    // reset; it clears after one full clean sweep or after a release.
    logic             lock_q,    lock_d;
    logic [1:0]       clean_q,   clean_d;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [REP_W-1:0] rep_q,     rep_d;
`endif

    logic       w_sample;
    logic       w_all_high;
    logic [1:0] w_low_col;

    // Lowest-index low column wins when several keys share a row
    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        logic [1:0] idx;
        if (!c[0])      idx = 2'd0;
        else if (!c[1]) idx = 2'd1;
        else if (!c[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    // Calculator key map, row-major
    function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hC;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hD;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hE;
            4'b11_00: code = 4'hB;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hA;
            default:  code = 4'hF;
        endcase
        return code;
    endfunction

    assign w_sample   = (div_q == DIV_LAST);
    assign w_all_high = (cols_sync_q == 4'hF);
    assign w_low_col  = lowest_low(cols_sync_q);

    // Two-flop synchronizer for the asynchronous column inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cols_meta_q <= 4'hF;
            cols_sync_q <= 4'hF;
        end else begin
            cols_meta_q <= cols;
            cols_sync_q <= cols_meta_q;
        end
    end

    // State and datapath register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_SCAN;
            div_q     <= '0;
            row_q     <= 2'd0;
            pattern_q <= 4'hF;
            col_q     <= 2'd0;
            match_q   <= '0;
            rel_q     <= '0;
            stb_q     <= '0;
            key_q     <= 4'h0;
            lock_q    <= 1'b1;
            clean_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            row_q     <= row_d;
            pattern_q <= pattern_d;
            col_q     <= col_d;
            match_q   <= match_d;
            rel_q     <= rel_d;
            stb_q     <= stb_d;
            key_q     <= key_d;
            lock_q    <= lock_d;
            clean_q   <= clean_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat held-sample counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        pattern_d = pattern_q;
        col_d     = col_q;
        match_d   = match_q;
        rel_d     = rel_q;
        stb_d     = stb_q;
        key_d     = key_q;
        lock_d    = lock_q;
        clean_d   = clean_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d     = rep_q;
`endif

        // The dwell is held at zero during a strobe so that the release and
        // repeat windows after it start on a whole dwell.
        if (state_q == ST_STROBE || w_sample) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            ST_SCAN: begin
                if (w_sample) begin
                    if (w_all_high) begin
                        row_d = row_q + 2'd1;
                        if (clean_q == 2'd3) begin
                            lock_d = 1'b0;
                        end else begin
                            clean_d = clean_q + 2'd1;
                        end
                    end else begin
                        clean_d   = 2'd0;
                        pattern_d = cols_sync_q;
                        col_d     = w_low_col;
                        match_d   = DEB_W'(1);
                        rel_d     = '0;
                        if (lock_q) begin
                            // Possibly held through reset: wait it out silently
                            state_d = ST_WAIT_RELEASE;
                        end else if (DEBOUNCE_SCANS == 1) begin
                            key_d   = encode(row_q, w_low_col);
                            stb_d   = '0;
                            state_d = ST_STROBE;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (w_sample) begin
                    if (cols_sync_q == pattern_q) begin
                        if (match_q == DEB_LAST) begin
                            key_d   = encode(row_q, col_q);
                            stb_d   = '0;
                            state_d = ST_STROBE;
                        end else begin
                            match_d = match_q + DEB_W'(1);
                        end
                    end else begin
                        state_d = ST_SCAN;
                        row_d   = row_q + 2'd1;
                    end
                end
            end

            ST_STROBE: begin
                if (stb_q == STB_LAST) begin
                    state_d = ST_WAIT_RELEASE;
                    rel_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d   = '0;
`endif
                end else begin
                    stb_d = stb_q + STB_W'(1);
                end
            end

            ST_WAIT_RELEASE: begin
                if (w_sample) begin
                    if (w_all_high) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d = '0;
`endif
                        if (rel_q == DEB_LAST) begin
                            state_d = ST_SCAN;
                            row_d   = row_q + 2'd1;
                            lock_d  = 1'b0;
                        end else begin
                            rel_d = rel_q + DEB_W'(1);
                        end
                    end else begin
                        rel_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        // Same key still held: re-strobe after enough samples
                        if (!lock_q && cols_sync_q == pattern_q) begin
                            if (rep_q == REP_LAST) begin
                                rep_d   = '0;
                                stb_d   = '0;
                                state_d = ST_STROBE;
                            end else begin
                                rep_d = rep_q + REP_W'(1);
                            end
                        end else begin
                            rep_d = '0;
                        end
`else
                        // A held key simply waits for its release
`endif
                    end
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        rows       = ~(4'b0001 << row_q);
        kbEN       = (state_q == ST_STROBE);
        pressedkey = key_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner. A keypad model drives
//                the columns from the row drive and a pressed-key bitmap;
//                expected key codes are queued with each stimulus and popped
//                on every kbEN rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int KBEN_CYCLES    = 2;
    localparam int REPEAT_SAMPLES = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  pressedkey;
    logic        kbEN;
    logic [15:0] keys = '0;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  exp_q[$];

    logic        kb_prev = 1'b0;
    int          hi_len = 0;
    logic [3:0]  key_at_rise = 4'h0;
    int          rise_cnt = 0;
    time         rise_t = 0;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .KBEN_CYCLES    (KBEN_CYCLES),
        .REPEAT_SAMPLES (REPEAT_SAMPLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cols       (cols),
        .rows       (rows),
        .pressedkey (pressedkey),
        .kbEN       (kbEN)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its column low while its row is driven
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: pops the scoreboard on each rise, checks width/stability
    always @(negedge clk) begin
        if (rst) begin
            kb_prev = 1'b0;
            hi_len  = 0;
        end else begin
            if (kbEN && !kb_prev) begin
                rise_cnt++;
                rise_t      = $time;
                key_at_rise = pressedkey;
                hi_len      = 1;
                check("strobe_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("strobe_code", pressedkey, exp_q.pop_front());
            end else if (kbEN) begin
                hi_len++;
                check("key_stable_high", pressedkey, key_at_rise);
            end else if (kb_prev) begin
                check("kben_width", hi_len, KBEN_CYCLES);
                check("key_after_fall", pressedkey, key_at_rise);
            end
            kb_prev = kbEN;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int maxcyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxcyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_rows;
        int         base;
        int         n;
        int         n_exp;
        time        low_t;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rows", rows, 4'b1110);
        check("reset_key", pressedkey, 4'h0);
        check("reset_kben", kbEN, 1'b0);
        rst = 1'b0;

        // Idle scan: one row per dwell of 4 cycles
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_rows = ~(4'b0001 << ((k / 4) % 4));
            check("idle_rows", rows, exp_rows);
        end
        check("idle_no_strobe", rise_cnt, 0);

        // Single key, row 1 col 2 -> 6, with latency bound
        base = rise_cnt;
        exp_q.push_back(4'h6);
        keys[6] = 1'b1;
        n = 0;
        while (cols == 4'hF && n < 40) begin
            @(negedge clk);
            n++;
        end
        low_t = $time;
        wait_drain("strobe_key6", 40);
        check("latency_key6", ((rise_t - low_t) / 10) <= 15, 1'b1);
        idle(20);
        check("one_strobe_key6", rise_cnt - base, 1);
        keys = '0;
        idle(30);

        // Bouncing contact on row 3 col 3
        base = rise_cnt;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) keys[15] = ~keys[15];
            @(negedge clk);
        end
        check("bounce_no_strobe", rise_cnt - base, 0);
        keys[15] = 1'b1;
        exp_q.push_back(4'hF);
        wait_drain("strobe_bounce", 50);
        keys = '0;
        idle(30);

        // Two keys on row 0: lowest column wins; other rows ignored while held
        base = rise_cnt;
        exp_q.push_back(4'h2);
        keys[1] = 1'b1;
        keys[3] = 1'b1;
        wait_drain("strobe_multi", 50);
        keys[8] = 1'b1;
        idle(40);
        check("other_row_ignored", rise_cnt - base, 1);
        keys = '0;
        idle(30);
        exp_q.push_back(4'h7);
        keys[8] = 1'b1;
        wait_drain("strobe_row2", 50);
        keys = '0;
        idle(30);

        // Reset during the first strobe cycle, key held across reset
        exp_q.push_back(4'h6);
        keys[6] = 1'b1;
        n = 0;
        while (!kbEN && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_strobe", kbEN, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_kben", kbEN, 1'b0);
        check("rst_mid_key", pressedkey, 4'h0);
        check("rst_mid_rows", rows, 4'b1110);
        check("rst_strobe_popped", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = rise_cnt;
        idle(80);
        check("held_across_rst", rise_cnt - base, 0);
        keys = '0;
        idle(30);
        exp_q.push_back(4'h6);
        keys[6] = 1'b1;
        wait_drain("strobe_after_rst", 60);
        keys = '0;
        idle(30);

        // Hold row 3 col 2 (equal) for 200 cycles from the start of its dwell
        n = 0;
        while (rows == 4'b0111 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (rows != 4'b0111 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("row3_active", rows, 4'b0111);
        base  = rise_cnt;
        n_exp = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
        // First rise 12 cycles after the dwell start, then every 22 cycles
        for (int t = 12; t < 200; t += 22) begin
            exp_q.push_back(4'hA);
            n_exp++;
        end
`else
        exp_q.push_back(4'hA);
        n_exp = 1;
`endif
        keys[14] = 1'b1;
        idle(200);
        keys = '0;
        wait_drain("strobe_hold", 40);
        idle(30);
        check("hold_strobe_count", rise_cnt - base, n_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
